// File: rtl/canny_pkg.sv
// Shared types for the Canny front end: buffer shift directions and the
// window-scan sequencer state encoding.
package canny_pkg;

  localparam int unsigned STRIP_LEN = 5;
  localparam int unsigned FILL_W    = 3;

  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_RIGHT = 2'b01,
    SHIFT_LEFT  = 2'b10,
    SHIFT_DOWN  = 2'b11
  } shift_dir_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_e;

endpackage

// File: rtl/buffer_scan_ctrl_if.sv
// Strip-fetch, buffer-shift and window-handshake signals between the scan
// sequencer (master) and the fetch unit / window buffer / gradient stage (slave).
interface buffer_scan_ctrl_if #(
  parameter int unsigned COORD_W = 10
);
  import canny_pkg::*;

  logic               fetch_req;
  logic               fetch_col;
  logic [COORD_W-1:0] fetch_x;
  logic [COORD_W-1:0] fetch_y;
  logic               fetch_done;
  logic               shift_enable;
  shift_dir_e         shift_direction;
  logic               window_valid;
  logic               window_ready;
  logic [COORD_W-1:0] win_x;
  logic [COORD_W-1:0] win_y;

  modport master (
    output fetch_req, fetch_col, fetch_x, fetch_y,
    output shift_enable, shift_direction,
    output window_valid, win_x, win_y,
    input  fetch_done, window_ready
  );

  modport slave (
    input  fetch_req, fetch_col, fetch_x, fetch_y,
    input  shift_enable, shift_direction,
    input  window_valid, win_x, win_y,
    output fetch_done, window_ready
  );

endinterface

// File: rtl/buffer_scan_ctrl.sv
// Serpentine scan sequencer for the 5x5 window buffer: fills the buffer,
// then walks right/down/left bands, presenting each window via valid/ready.
module buffer_scan_ctrl
  import canny_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64,
  parameter int unsigned COORD_W    = 10
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  buffer_scan_ctrl_if.master bus
);

  localparam logic [COORD_W-1:0] X_END     = COORD_W'(IMG_WIDTH - STRIP_LEN);
  localparam logic [COORD_W-1:0] Y_END     = COORD_W'(IMG_HEIGHT - STRIP_LEN);
  localparam logic [COORD_W-1:0] STRIP     = COORD_W'(STRIP_LEN);
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
  localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(STRIP_LEN - 1);

  scan_state_e        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  shift_dir_e         dir_q, dir_d, move_q, move_d;
  logic               filling_q, filling_d;

  logic               fetch_req_q, fetch_req_d, fetch_col_q, fetch_col_d;
  logic [COORD_W-1:0] fetch_x_q, fetch_x_d, fetch_y_q, fetch_y_d;
  logic               shift_en_q, shift_en_d;
  shift_dir_e         shift_dir_q, shift_dir_d;
  logic               win_valid_q, win_valid_d;
  logic [COORD_W-1:0] win_x_q, win_x_d, win_y_q, win_y_d;
  logic               busy_q, busy_d, frame_done_q, frame_done_d;
  logic               band_end_c;

  assign band_end_c = ((dir_q == SHIFT_RIGHT) && (x_q == X_END)) ||
                      ((dir_q == SHIFT_LEFT)  && (x_q == '0));

  // Scan position and state sequencing
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    fill_d    = fill_q;
    dir_d     = dir_q;
    move_d    = move_q;
    filling_d = filling_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d       = '0;
          y_d       = '0;
          fill_d    = '0;
          dir_d     = SHIFT_RIGHT;
          move_d    = SHIFT_RIGHT;
          filling_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.fetch_done) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (filling_q && (fill_q < FILL_LAST)) begin
          fill_d  = fill_q + FILL_W'(1);
          state_d = ST_FETCH;
        end else if (filling_q) begin
          filling_d = 1'b0;
          state_d   = ST_EMIT;
        end else begin
          case (move_q)
            SHIFT_RIGHT: x_d = x_q + ONE;
            SHIFT_LEFT:  x_d = x_q - ONE;
            SHIFT_DOWN:  y_d = y_q + ONE;
            default:     ;
          endcase
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.window_ready) begin
          if (band_end_c && (y_q == Y_END)) begin
            state_d = ST_DONE;
          end else if (band_end_c) begin
            move_d  = SHIFT_DOWN;
            dir_d   = (dir_q == SHIFT_RIGHT) ? SHIFT_LEFT : SHIFT_RIGHT;
            state_d = ST_FETCH;
          end else begin
            move_d  = dir_q;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop
  always_comb begin
    fetch_req_d  = 1'b0;
    fetch_col_d  = 1'b0;
    fetch_x_d    = '0;
    fetch_y_d    = '0;
    shift_en_d   = 1'b0;
    shift_dir_d  = SHIFT_NONE;
    win_valid_d  = 1'b0;
    win_x_d      = '0;
    win_y_d      = '0;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
    case (state_d)
      ST_FETCH: begin
        fetch_req_d = 1'b1;
        if (filling_d) begin
          fetch_col_d = 1'b1;
          fetch_x_d   = COORD_W'(fill_d);
        end else begin
          case (move_d)
            SHIFT_RIGHT: begin fetch_col_d = 1'b1; fetch_x_d = x_d + STRIP; fetch_y_d = y_d; end
            SHIFT_LEFT:  begin fetch_col_d = 1'b1; fetch_x_d = x_d - ONE;   fetch_y_d = y_d; end
            SHIFT_DOWN:  begin fetch_col_d = 1'b0; fetch_x_d = x_d;         fetch_y_d = y_d + STRIP; end
            default:     ;
          endcase
        end
      end
      ST_SHIFT: begin
        shift_en_d  = 1'b1;
        shift_dir_d = filling_d ? SHIFT_RIGHT : move_d;
      end
      ST_EMIT: begin
        win_valid_d = 1'b1;
        win_x_d     = x_d;
        win_y_d     = y_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      fill_q       <= '0;
      dir_q        <= SHIFT_NONE;
      move_q       <= SHIFT_NONE;
      filling_q    <= 1'b0;
      fetch_req_q  <= 1'b0;
      fetch_col_q  <= 1'b0;
      fetch_x_q    <= '0;
      fetch_y_q    <= '0;
      shift_en_q   <= 1'b0;
      shift_dir_q  <= SHIFT_NONE;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      fill_q       <= fill_d;
      dir_q        <= dir_d;
      move_q       <= move_d;
      filling_q    <= filling_d;
      fetch_req_q  <= fetch_req_d;
      fetch_col_q  <= fetch_col_d;
      fetch_x_q    <= fetch_x_d;
      fetch_y_q    <= fetch_y_d;
      shift_en_q   <= shift_en_d;
      shift_dir_q  <= shift_dir_d;
      win_valid_q  <= win_valid_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.fetch_req       = fetch_req_q;
  assign bus.fetch_col       = fetch_col_q;
  assign bus.fetch_x         = fetch_x_q;
  assign bus.fetch_y         = fetch_y_q;
  assign bus.shift_enable    = shift_en_q;
  assign bus.shift_direction = shift_dir_q;
  assign bus.window_valid    = win_valid_q;
  assign bus.win_x           = win_x_q;
  assign bus.win_y           = win_y_q;
  assign busy                = busy_q;
  assign frame_done          = frame_done_q;

endmodule

// File: doc/buffer_scan_ctrl.md
# buffer_scan_ctrl

Sequencer for the 5x5 pixel window buffer in the Canny front end. It walks a serpentine scan over an IMG_WIDTH x IMG_HEIGHT image, requesting 5-pixel strips from the fetch unit. It drives the buffer's shift_enable/shift_direction and presents each complete window to the downstream gradient stage through a valid/ready handshake.

## Interface
- IMG_WIDTH, 64, image width in pixels (≥5)
- IMG_HEIGHT, 64, image height in pixels (≥5)
- COORD_W, 10, coordinate width; 2^COORD_W > max(IMG_WIDTH, IMG_HEIGHT)
- clk  in  1  system clock
- n_rst  in  1  reset; one clock, asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a frame scan (honoured only in IDLE)
- fetch_req  out  1  strip request, held until fetch_done
- fetch_col  out  1  1 = vertical 5-pixel column, 0 = horizontal 5-pixel row
- fetch_x, fetch_y  out  COORD_W  top/left pixel of requested strip
- fetch_done  in  1  pulse; strip is stable on buffer_input this cycle and next
- shift_enable  out  1  buffer shift strobe
- shift_direction  out  2  00 none, 01 right (new column enters right), 10 left, 11 down (new row enters bottom)
- window_valid  out  1  buffer holds a complete window
- window_ready  in  1  downstream accepts window
- win_x, win_y  out  COORD_W  top-left coordinate of presented window
- busy  out  1  high from the cycle after accepted start until DONE exits
- frame_done  out  1  one-cycle pulse after the last window is accepted

## Operation
- States: IDLE, FETCH, SHIFT, EMIT, DONE.
- IDLE: all outputs 0. On start: x=0, y=0, fill=0, dir=RIGHT, filling=1 → FETCH.
- FETCH: fetch_req=1 with coordinates below; on fetch_done → SHIFT. fetch_req is low in the cycle after fetch_done.
- Strip coordinates:
  - Fill: (fill, 0), col=1.
  - Moving right: (x+5, y), col=1.
  - Moving left: (x-1, y), col=1.
  - Down: (x, y+5), col=0.
- SHIFT: shift_enable=1 for exactly one cycle, with shift_direction = RIGHT during fill, else the pending move. Coordinates update in the same cycle: right x+1, left x−1, down y+1.
  - During fill with fill<4: fill+1 → FETCH.
  - Otherwise: filling=0 → EMIT.
- EMIT: window_valid=1, win_x=x, win_y=y, held stable until window_ready. On the handshake cycle:
  - Last window (y=IMG_HEIGHT−5, and x at the band end for the current dir) → DONE.
  - Band end (dir RIGHT and x=IMG_WIDTH−5, or dir LEFT and x=0) → pending move DOWN, dir toggles → FETCH.
  - Else pending move = dir → FETCH.
- DONE: frame_done=1 for one cycle → IDLE.
- shift_direction is 00 whenever shift_enable=0.
- Windows per frame: (IMG_WIDTH−4)·(IMG_HEIGHT−4). Shifts per frame: 5 + windows − 1.
- Coordinate arithmetic is unsigned COORD_W. Underflow/overflow cannot occur for legal parameters.
- start while busy: ignored. window_ready outside EMIT: ignored. fetch_done outside FETCH: ignored.
- Reset at any point: immediate return to IDLE, all outputs 0, scan position discarded.

## Timing
- Reset values: every output 0; state IDLE.
- start at cycle n: busy=1 and fetch_req=1 at n+1.
- fetch_done at cycle m: shift_enable=1 at m+1.
  - Next FETCH (fill) begins m+2.
  - Otherwise window_valid=1 at m+2.
- Handshake at cycle k: window_valid=0 and fetch_req=1 at k+1; or frame_done=1 at k+1.
- Minimum cost per window after fill: 3 cycles plus fetch latency.

## Structure
- Shared package canny_pkg holds:
  - shift direction typedef (SHIFT_NONE, SHIFT_RIGHT, SHIFT_LEFT, SHIFT_DOWN with the encodings above), reused by the buffer;
  - scan state typedef.
- No sub-module. A single FSM with x/y/fill counters is natural.

## Test plan
Bench parameters: IMG_WIDTH=8, IMG_HEIGHT=7; fetch responder returns fetch_done 2 cycles after fetch_req.

1. Reset, then idle 10 cycles → all outputs 0. start pulse → fetch_req at next cycle with (0,0), col=1.
2. Fill → five fetches at x=0..4, y=0, each followed by one RIGHT shift. First window_valid with win=(0,0).
3. Full frame with window_ready always 1 → 12 windows in order (0,0)…(3,0),(3,1)…(0,1),(0,2)…(3,2). Directions at band ends: DOWN fetch (3,5) col=0, then (0,6) col=0. frame_done once, busy drops, total 16 shifts.
4. Backpressure: window_ready held 0 for 6 cycles at window (2,0) → window_valid/win stable, no fetch_req or shift until ready.
5. start asserted mid-frame, and spurious fetch_done/window_ready in wrong states → no change to the sequence.
6. n_rst asserted during the FETCH for window (1,1) → outputs 0 immediately. New start restarts fill at (0,0).
